// File: rtl/baud_pkg.sv
// baud_pkg: shared clock/baud constants and divisor computation
// for the UART baud tick generator.
package baud_pkg;

    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int DEFAULT_BAUD = 9600;
    localparam int OVERSAMPLE   = 16;
    localparam int DEF_FRAC_W   = 4;

    // Fixed-point clk/(baud*os), rounded to the nearest 1/2^frac_w cycle.
    function automatic logic [63:0] calc_div_q(
        input int clk_hz,
        input int baud,
        input int os,
        input int frac_w
    );
        logic [63:0] num;
        logic [63:0] den;
        den = 64'(baud) * 64'(os);
        num = (64'(clk_hz) << frac_w) + (den >> 1);
        return num / den;
    endfunction

    function automatic int calc_div_int(
        input int clk_hz,
        input int baud,
        input int os,
        input int frac_w
    );
        return int'(calc_div_q(clk_hz, baud, os, frac_w) >> frac_w);
    endfunction

    function automatic int calc_div_frac(
        input int clk_hz,
        input int baud,
        input int os,
        input int frac_w
    );
        logic [63:0] mask;
        mask = (64'd1 << frac_w) - 64'd1;
        return int'(calc_div_q(clk_hz, baud, os, frac_w) & mask);
    endfunction

    localparam int DEF_DIV_INT =
        calc_div_int(CLK_FREQ_HZ, DEFAULT_BAUD, OVERSAMPLE, DEF_FRAC_W);
    localparam int DEF_DIV_FRAC =
        calc_div_frac(CLK_FREQ_HZ, DEFAULT_BAUD, OVERSAMPLE, DEF_FRAC_W);

endpackage

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: fractional-N oversample tick generator with
// bit-midpoint and bit-boundary ticks derived from the phase count.
module baud_rate_gen #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = baud_pkg::DEF_FRAC_W,
    parameter int OVERSAMPLE   = baud_pkg::OVERSAMPLE,
    parameter int RST_DIV_INT  = baud_pkg::DEF_DIV_INT,
    parameter int RST_DIV_FRAC = baud_pkg::DEF_DIV_FRAC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          load,
    input  logic                          sync_clr,
    output logic                          tick_os,
    output logic                          tick_mid,
    output logic                          tick_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          cfg_err
);
    import baud_pkg::*;

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_MID = PH_W'(OVERSAMPLE / 2);

    logic [DIV_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic [DIV_W:0]    r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;
    logic [PH_W-1:0]   r_phase;
    logic              r_tick_os;
    logic              r_tick_mid;
    logic              r_tick_bit;

    logic [DIV_W:0]    w_div_ext;
    logic [DIV_W:0]    w_last;
    logic              w_wrap;
    logic [FRAC_W:0]   w_sum;
    logic [PH_W-1:0]   w_phase_nx;
    logic              w_cfg_err;

    // A carry stretches the current interval by one cycle.
    assign w_div_ext  = {1'b0, r_div_int};
    assign w_last     = r_carry ? w_div_ext
                                : w_div_ext - (DIV_W+1)'(1);
    assign w_wrap     = (r_cnt == w_last);
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_div_frac};
    assign w_phase_nx = r_phase + PH_W'(1);
    assign w_cfg_err  = (r_div_int < DIV_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_int  <= DIV_W'(RST_DIV_INT);
            r_div_frac <= FRAC_W'(RST_DIV_FRAC);
            r_cnt      <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_phase    <= '0;
            r_tick_os  <= 1'b0;
            r_tick_mid <= 1'b0;
            r_tick_bit <= 1'b0;
        end else begin
            r_tick_os  <= 1'b0;
            r_tick_mid <= 1'b0;
            r_tick_bit <= 1'b0;
            if (load) begin
                r_div_int  <= div_int;
                r_div_frac <= div_frac;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_carry    <= 1'b0;
                r_phase    <= '0;
            end else if (sync_clr) begin
                r_cnt      <= '0;
                r_carry    <= 1'b0;
                r_phase    <= '0;
            end else if (en && !w_cfg_err) begin
                if (w_wrap) begin
                    r_cnt      <= '0;
                    r_acc      <= w_sum[FRAC_W-1:0];
                    r_carry    <= w_sum[FRAC_W];
                    r_phase    <= w_phase_nx;
                    r_tick_os  <= 1'b1;
                    r_tick_mid <= (w_phase_nx == PH_MID);
                    r_tick_bit <= (w_phase_nx == '0);
                end else begin
                    r_cnt <= r_cnt + (DIV_W+1)'(1);
                end
            end
        end
    end

    assign tick_os  = r_tick_os;
    assign tick_mid = r_tick_mid;
    assign tick_bit = r_tick_bit;
    assign os_phase = r_phase;
    assign cfg_err  = w_cfg_err;

endmodule

// File: tb/tb_baud_rate_gen.sv
// tb_baud_rate_gen: randomized and directed checks of baud_rate_gen
// against an interval-list reference model.
module tb_baud_rate_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        sync_clr = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        tick_os;
    logic        tick_mid;
    logic        tick_bit;
    logic [3:0]  os_phase;
    logic        cfg_err;

    logic        rst2 = 1'b1;
    logic        en2 = 1'b1;
    logic        load2 = 1'b0;
    logic        sync2 = 1'b0;
    logic [2:0]  div_int2 = '0;
    logic [1:0]  div_frac2 = '0;
    logic        d2_tos;
    logic        d2_mid;
    logic        d2_bit;
    logic [1:0]  d2_ph;
    logic        d2_err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: restart point, ticks since restart, countdown
    int m_div, m_frac, m_a0, m_k, m_remain, m_ph;
    logic m_tos, m_tmid, m_tbit;

    baud_rate_gen dut (
        .clk(clk), .rst(rst), .en(en),
        .div_int(div_int), .div_frac(div_frac),
        .load(load), .sync_clr(sync_clr),
        .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
        .os_phase(os_phase), .cfg_err(cfg_err)
    );

    baud_rate_gen #(
        .DIV_W(3), .FRAC_W(2), .OVERSAMPLE(4),
        .RST_DIV_INT(7), .RST_DIV_FRAC(3)
    ) dut2 (
        .clk(clk), .rst(rst2), .en(en2),
        .div_int(div_int2), .div_frac(div_frac2),
        .load(load2), .sync_clr(sync2),
        .tick_os(d2_tos), .tick_mid(d2_mid), .tick_bit(d2_bit),
        .os_phase(d2_ph), .cfg_err(d2_err)
    );

    always #5 clk = ~clk;

    // Length of interval k after a restart with accumulator a0.
    function automatic int exp_interval(int d, int f, int fw, int a0, int k);
        if (k == 0) return d;
        return d + (a0 + k * f) / (1 << fw) - (a0 + (k - 1) * f) / (1 << fw);
    endfunction

    function automatic void restart(int a0);
        m_a0 = a0;
        m_k = 0;
        m_remain = m_div;
        m_ph = 0;
    endfunction

    function automatic void model_step();
        m_tos = 1'b0;
        m_tmid = 1'b0;
        m_tbit = 1'b0;
        if (rst) begin
            m_div = 325;
            m_frac = 8;
            restart(0);
        end else if (load) begin
            m_div = int'(div_int);
            m_frac = int'(div_frac);
            restart(0);
        end else if (sync_clr) begin
            restart((m_a0 + m_k * m_frac) % 16);
        end else if (en && m_div >= 2) begin
            m_remain--;
            if (m_remain == 0) begin
                m_k++;
                m_remain = exp_interval(m_div, m_frac, 4, m_a0, m_k);
                m_ph = (m_ph + 1) % 16;
                m_tos = 1'b1;
                m_tbit = (m_ph == 0);
                m_tmid = (m_ph == 8);
            end
        end
    endfunction

    function automatic logic [7:0] obs_v();
        return {tick_os, tick_mid, tick_bit, os_phase, cfg_err};
    endfunction

    function automatic logic [7:0] exp_v();
        return {m_tos, m_tmid, m_tbit, 4'(m_ph), logic'(m_div < 2)};
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_load(input int d, input int f);
        div_int = 16'(d);
        div_frac = 4'(f);
        load = 1'b1;
        clk_step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        int t;
        rst = 1'b1;
        en = 1'b1;
        repeat (2) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL reset_state got %h want %h", obs_v(), exp_v());
            end
        end
        rst = 1'b0;
        t = 0;
        while (t < 400) begin
            clk_step();
            t++;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL reset_run t=%0d got %h want %h", t, obs_v(), exp_v());
            end
            if (tick_os) break;
        end
        n_cmp++;
        if (t !== 325) begin
            n_bad++;
            $display("FAIL reset_first_tick got %0d want 325", t);
        end
    endtask

    task automatic test_int_div();
        int t, b0, b1;
        b0 = -1;
        b1 = -1;
        do_load(4, 0);
        for (t = 1; t <= 200; t++) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL int_div t=%0d got %h want %h", t, obs_v(), exp_v());
            end
            if (tick_bit && b0 < 0) b0 = t;
            else if (tick_bit && b1 < 0) b1 = t;
        end
        n_cmp++;
        if (b0 !== 64 || b1 - b0 !== 64) begin
            n_bad++;
            $display("FAIL int_div_bit got %0d,%0d want 64,128", b0, b1);
        end
    endtask

    task automatic test_frac();
        int want[6] = '{4, 4, 5, 4, 5, 4};
        int t, last, n;
        last = 0;
        n = 0;
        do_load(4, 8);
        for (t = 1; t <= 60; t++) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL frac t=%0d got %h want %h", t, obs_v(), exp_v());
            end
            if (tick_os && n < 6) begin
                n_cmp++;
                if (t - last !== want[n]) begin
                    n_bad++;
                    $display("FAIL frac_interval %0d got %0d want %0d", n, t - last, want[n]);
                end
                n++;
                last = t;
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [3:0] ph;
        do_load(6, 5);
        repeat (9) clk_step();
        ph = os_phase;
        en = 1'b0;
        repeat (10) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v() || os_phase !== ph) begin
                n_bad++;
                $display("FAIL en_hold got %h want %h", obs_v(), exp_v());
            end
        end
        en = 1'b1;
        repeat (40) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL en_resume got %h want %h", obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_sync_clr();
        int t;
        do_load(4, 8);
        t = 0;
        while (os_phase !== 4'd5 && t < 100) begin
            clk_step();
            t++;
        end
        n_cmp++;
        if (os_phase !== 4'd5) begin
            n_bad++;
            $display("FAIL sync_reach_phase got %0d want 5", os_phase);
        end
        clk_step();
        sync_clr = 1'b1;
        clk_step();
        sync_clr = 1'b0;
        n_cmp++;
        if (obs_v() !== exp_v() || os_phase !== 4'd0) begin
            n_bad++;
            $display("FAIL sync_clr got %h want %h", obs_v(), exp_v());
        end
        t = 0;
        while (t < 20) begin
            clk_step();
            t++;
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL sync_run got %h want %h", obs_v(), exp_v());
            end
            if (tick_os) break;
        end
        n_cmp++;
        if (t !== 4) begin
            n_bad++;
            $display("FAIL sync_first_tick got %0d want 4", t);
        end
        repeat (40) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL sync_after got %h want %h", obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_cfg_err();
        do_load(1, 3);
        n_cmp++;
        if (cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_err_set got %b want 1", cfg_err);
        end
        repeat (20) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL cfg_err_hold got %h want %h", obs_v(), exp_v());
            end
        end
        do_load(0, 7);
        do_load(325, 8);
        repeat (330) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL cfg_err_clear got %h want %h", obs_v(), exp_v());
            end
        end
        sync_clr = 1'b1;
        do_load(3, 0);
        sync_clr = 1'b0;
        repeat (20) begin
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL load_vs_sync got %h want %h", obs_v(), exp_v());
            end
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            rst = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 149) == 0);
            sync_clr = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) < 8);
            div_int = 16'($urandom_range(0, 12));
            div_frac = 4'($urandom_range(0, 15));
            clk_step();
            n_cmp++;
            if (obs_v() !== exp_v()) begin
                n_bad++;
                $display("FAIL random got %h want %h", obs_v(), exp_v());
            end
        end
        rst = 1'b0;
        load = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic test_div_max();
        int t, last, n;
        rst2 = 1'b1;
        clk_step();
        rst2 = 1'b0;
        n_cmp++;
        if (d2_err !== 1'b0 || d2_tos !== 1'b0 || d2_ph !== 2'd0) begin
            n_bad++;
            $display("FAIL max_reset got %b%b%h want 000", d2_err, d2_tos, d2_ph);
        end
        last = 0;
        n = 0;
        for (t = 1; t <= 120 && n < 8; t++) begin
            clk_step();
            if (d2_tos) begin
                n_cmp++;
                if (t - last !== exp_interval(7, 3, 2, 0, n)
                    || d2_bit !== ((n + 1) % 4 == 0)
                    || d2_mid !== ((n + 1) % 4 == 2)) begin
                    n_bad++;
                    $display("FAIL max_interval %0d got %0d/%b%b want %0d",
                             n, t - last, d2_bit, d2_mid,
                             exp_interval(7, 3, 2, 0, n));
                end
                n++;
                last = t;
            end
        end
        n_cmp++;
        if (n !== 8) begin
            n_bad++;
            $display("FAIL max_tick_count got %0d want 8", n);
        end
    endtask

    initial begin
        m_div = 325;
        m_frac = 8;
        restart(0);
        m_tos = 1'b0;
        m_tmid = 1'b0;
        m_tbit = 1'b0;
        test_reset();
        test_int_div();
        test_frac();
        test_enable_hold();
        test_sync_clr();
        test_cfg_err();
        test_random();
        test_div_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
